flag_event_qualifier: RTL and testbench
=======================================

Name: flag_event_qualifier

Overview:
Destination-domain consumer of a synchronized, pulse-stretched flag. The flag arrives as a multi-cycle level from the upstream clock-domain-crossing stage. This block:
- glitch-qualifies the level,
- converts each qualified high period into exactly one event,
- queues events in a saturating pending counter,
- presents them to downstream logic over a valid/ready handshake (e.g. resync/reconfigure requests in the video pipeline).

Parameters:
MIN_HIGH, 4, consecutive high samples of flag_in required to qualify an event (legal range >= 1).
MIN_LOW, 2, consecutive low samples of flag_in required to re-arm after an event (legal range >= 1).
CNT_W, 4, width of the pending event counter; saturates at 2^CNT_W-1.

Ports:
clock  input  1  single clock; every register in the block is clocked on its rising edge.
reset  input  1  synchronous, active-high reset.
flag_in  input  1  stretched flag, already synchronized into this clock domain; treated as an ordinary synchronous input.
event_valid  output  1  high while at least one event is pending.
event_ready  input  1  downstream accepts one event per cycle when event_valid=1.
pending_count  output  CNT_W  number of events queued.
overflow  output  1  sticky; set when an event is lost at saturation.
clear_overflow  input  1  synchronous clear of overflow.
armed  output  1  high when the qualifier is in the ARMED state (debug/status).

Behaviour:
- Reset values:
  - state = WAIT_LOW, internal sample counter cnt = 0.
  - pending_count = 0, event_valid = 0, overflow = 0, armed = 0.
  - Reset into WAIT_LOW is deliberate: a flag held high through and after reset (upstream initialised high) never produces an event.
- Reset asserted mid-operation discards all pending events and qualifier progress the same edge; the clear of pending events is not handshaked.
- Qualifier FSM, two states plus cnt. cnt is sized to hold max(MIN_HIGH, MIN_LOW).
  - ARMED, flag_in=1: cnt <= cnt+1. If cnt+1 == MIN_HIGH, assert internal strobe fire this cycle, go to WAIT_LOW, cnt <= 0.
  - ARMED, flag_in=0: cnt <= 0.
  - WAIT_LOW, flag_in=0: cnt <= cnt+1. If cnt+1 == MIN_LOW, go to ARMED, cnt <= 0.
  - WAIT_LOW, flag_in=1: cnt <= 0. The flag must then be low for MIN_LOW consecutive samples again before re-arming.
- armed = (state == ARMED), registered with the state.
- Event latency:
  - fire is combinational from state/cnt/flag_in.
  - pending_count updates on the same edge that samples the MIN_HIGH-th consecutive high.
  - event_valid is visible in the following cycle.
  - At most one event per high period, regardless of its length.
- Pending counter update per edge, where acc = event_valid & event_ready:
  - fire & !acc: pending+1. If pending is already at max, it holds at max and overflow <= 1.
  - !fire & acc: pending-1.
  - fire & acc: unchanged (even at max; no overflow).
  - Neither: unchanged.
- event_valid = (pending_count != 0), driven from registered state with no combinational path from event_ready.
- Handshake rules:
  - event_ready while event_valid=0 has no effect; the counter never underflows.
  - event_valid stays high until acceptance.
- overflow precedence: set beats clear_overflow in the same cycle. Otherwise clear_overflow drives overflow to 0 on the next edge.

Test Plan:
- Reset released with flag_in held 1 for 20 cycles -> armed=0, pending_count=0 throughout. Then flag_in 0 for 2 cycles -> armed=1. Then flag_in 1 for 4 cycles (event_ready=0) -> pending_count=1 after the 4th high edge, event_valid=1 the next cycle.
- Glitch filtering (armed state): flag_in high 3 cycles, low 1, high 3 -> no event, cnt restarts each time. A high for 9 cycles -> exactly one event.
- Queue/drain: 3 qualified events with event_ready=0 -> pending_count=3. Then event_ready=1 -> count 2,1,0 on consecutive edges, event_valid falls after the 3rd accept; a 4th ready cycle leaves the count at 0.
- Simultaneous fire and accept with pending_count=2 -> pending_count stays 2. At pending_count=15 (CNT_W=4) -> stays 15, overflow stays 0.
- Saturation: 16 events with event_ready=0 -> pending_count=15, overflow=1. Pulse clear_overflow alone -> overflow=0. clear_overflow coincident with a 17th lost event -> overflow=1.
- Reset mid-stream: pending_count=5, cnt mid-qualification, reset for 1 cycle -> next cycle pending_count=0, event_valid=0, overflow=0, armed=0. A flag high during reset is ignored until MIN_LOW lows have been seen.

Source files
------------

// File: rtl/flag_event_qualifier.sv
// ----------------------------------------------------------------------------
// flag_event_qualifier
//
// Destination-domain consumer of a synchronized, pulse-stretched flag. The
// flag is glitch-qualified (MIN_HIGH consecutive highs), each qualified high
// period produces exactly one event, events are queued in a saturating
// pending counter and handed downstream over a valid/ready handshake.
//
// State table (qualifier FSM)
//   state     | meaning
//   ----------+---------------------------------------------------------------
//   WAIT_LOW  | waiting for MIN_LOW consecutive low samples before re-arming;
//             | any high sample restarts the low count
//   ARMED     | counting consecutive high samples; the MIN_HIGH-th high fires
//             | one event and returns to WAIT_LOW
//
// Ports
//   clock           in   single clock, rising edge
//   reset           in   synchronous, active-high reset
//   flag_in         in   stretched flag, already synchronized to clock
//   event_valid     out  at least one event pending
//   event_ready     in   downstream accepts one event per cycle when valid
//   pending_count   out  [CNT_W-1:0] number of queued events (saturating)
//   overflow        out  sticky: an event was lost at saturation
//   clear_overflow  in   synchronous clear of overflow (a new loss wins)
//   armed           out  qualifier is in ARMED (status/debug)
// ----------------------------------------------------------------------------
module flag_event_qualifier #(
    parameter int MIN_HIGH = 4,
    parameter int MIN_LOW  = 2,
    parameter int CNT_W    = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flag_in,
    output logic             event_valid,
    input  logic             event_ready,
    output logic [CNT_W-1:0] pending_count,
    output logic             overflow,
    input  logic             clear_overflow,
    output logic             armed
);

    // Sample counter must reach max(MIN_HIGH, MIN_LOW) as its incremented
    // value, so size it for that count inclusive.
    localparam int MAX_RUN = (MIN_HIGH > MIN_LOW) ? MIN_HIGH : MIN_LOW;
    localparam int SMP_W   = (MAX_RUN < 2) ? 1 : $clog2(MAX_RUN + 1);

    localparam logic [SMP_W-1:0] HIGH_TC = SMP_W'(MIN_HIGH);
    localparam logic [SMP_W-1:0] LOW_TC  = SMP_W'(MIN_LOW);
    localparam logic [CNT_W-1:0] PEND_MAX = '1;

    typedef enum logic {
        ST_WAIT_LOW = 1'b0,
        ST_ARMED    = 1'b1
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [SMP_W-1:0]   cnt_q;
    logic [SMP_W-1:0]   cnt_d;
    logic [SMP_W-1:0]   cnt_inc;
    logic               fire;

    logic [CNT_W-1:0]   pend_q;
    logic [CNT_W-1:0]   pend_d;
    logic               ovf_q;
    logic               ovf_d;
    logic               accept;

    // ------------------------------------------------------------------
    // Qualifier FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            // Reset lands in WAIT_LOW so a flag stuck high across reset
            // cannot produce a spurious event.
            state_q <= ST_WAIT_LOW;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Qualifier FSM: next state, sample counter and fire strobe
    // ------------------------------------------------------------------
    assign cnt_inc = cnt_q + SMP_W'(1);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        fire    = 1'b0;

        unique case (state_q)
            ST_ARMED: begin
                if (flag_in) begin
                    if (cnt_inc == HIGH_TC) begin
                        fire    = 1'b1;
                        state_d = ST_WAIT_LOW;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end else begin
                    // A low sample in the middle of a high run is a glitch:
                    // qualification restarts from zero.
                    cnt_d = '0;
                end
            end
            ST_WAIT_LOW: begin
                if (!flag_in) begin
                    if (cnt_inc == LOW_TC) begin
                        state_d = ST_ARMED;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end else begin
                    cnt_d = '0;
                end
            end
            default: begin
                state_d = ST_WAIT_LOW;
                cnt_d   = '0;
            end
        endcase
    end

    assign armed = (state_q == ST_ARMED);

    // ------------------------------------------------------------------
    // Pending event counter and sticky overflow
    // ------------------------------------------------------------------
    // Valid comes only from the registered count, so there is no
    // combinational path from event_ready back to event_valid.
    assign event_valid = (pend_q != '0);
    assign accept      = event_valid & event_ready;

    always_comb begin
        pend_d = pend_q;
        ovf_d  = ovf_q;

        if (fire && !accept) begin
            if (pend_q == PEND_MAX) begin
                ovf_d = 1'b1;
            end else begin
                pend_d = pend_q + CNT_W'(1);
            end
        end else if (!fire && accept) begin
            pend_d = pend_q - CNT_W'(1);
        end

        // A loss in the same cycle as the clear must stay visible.
        if (clear_overflow && !(fire && !accept && (pend_q == PEND_MAX))) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pend_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            pend_q <= pend_d;
            ovf_q  <= ovf_d;
        end
    end

    assign pending_count = pend_q;
    assign overflow      = ovf_q;

endmodule

// File: tb/tb_flag_event_qualifier.sv
module tb_flag_event_qualifier;

    localparam int MIN_HIGH = 4;
    localparam int MIN_LOW  = 2;
    localparam int CNT_W    = 4;
    localparam int PMAX     = (1 << CNT_W) - 1;

    logic             clock = 1'b0;
    logic             reset;
    logic             flag_in;
    logic             event_valid;
    logic             event_ready;
    logic [CNT_W-1:0] pending_count;
    logic             overflow;
    logic             clear_overflow;
    logic             armed;

    int tests = 0;
    int fails = 0;

    typedef struct {
        int pend;
        bit valid;
        bit ovf;
        bit arm;
    } exp_t;

    exp_t exp_q[$];

    // behavioural model state (run lengths of the flag, not the RTL counter)
    int m_pend, run_hi, run_lo;
    bit m_ovf, m_armed;

    flag_event_qualifier #(
        .MIN_HIGH(MIN_HIGH),
        .MIN_LOW (MIN_LOW),
        .CNT_W   (CNT_W)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .flag_in       (flag_in),
        .event_valid   (event_valid),
        .event_ready   (event_ready),
        .pending_count (pending_count),
        .overflow      (overflow),
        .clear_overflow(clear_overflow),
        .armed         (armed)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d at %0t", tag, obs, expv, $time);
        end
    endtask

    task automatic model_step(input bit f, input bit r, input bit c, input bit rs);
        bit fire, acc, lost;
        if (rs) begin
            m_pend = 0; m_ovf = 0; m_armed = 0; run_hi = 0; run_lo = 0;
            return;
        end
        fire = 0;
        if (f) begin
            run_lo = 0;
            run_hi++;
            if (m_armed && run_hi == MIN_HIGH) begin
                fire = 1;
                m_armed = 0;
            end
        end else begin
            run_hi = 0;
            run_lo++;
            if (!m_armed && run_lo >= MIN_LOW) m_armed = 1;
        end
        acc  = (m_pend != 0) && r;
        lost = fire && !acc && (m_pend == PMAX);
        if (fire && !acc && !lost) m_pend++;
        else if (!fire && acc) m_pend--;
        if (lost) m_ovf = 1;
        else if (c) m_ovf = 0;
    endtask

    // One clock: drive inputs, push the expected post-edge outputs, then
    // pop and compare once the DUT has registered the edge.
    task automatic cyc(input bit f, input bit r, input bit c, input bit rs);
        exp_t e;
        flag_in = f; event_ready = r; clear_overflow = c; reset = rs;
        model_step(f, r, c, rs);
        e.pend = m_pend; e.valid = (m_pend != 0); e.ovf = m_ovf; e.arm = m_armed;
        exp_q.push_back(e);
        @(posedge clock);
        #1;
        e = exp_q.pop_front();
        chk("sb_pending", 32'(pending_count), 32'(e.pend));
        chk("sb_valid",   32'(event_valid),   32'(e.valid));
        chk("sb_overflow",32'(overflow),      32'(e.ovf));
        chk("sb_armed",   32'(armed),         32'(e.arm));
    endtask

    task automatic repeat_cyc(input int n, input bit f, input bit r);
        for (int i = 0; i < n; i++) cyc(f, r, 1'b0, 1'b0);
    endtask

    // One qualified event followed by the lows needed to re-arm.
    // r/c apply on the firing edge only.
    task automatic qual_event(input bit r, input bit c);
        repeat_cyc(MIN_HIGH - 1, 1'b1, 1'b0);
        cyc(1'b1, r, c, 1'b0);
        repeat_cyc(MIN_LOW, 1'b0, 1'b0);
    endtask

    initial begin
        flag_in = 1'b1; event_ready = 1'b0; clear_overflow = 1'b0; reset = 1'b1;

        // reset with the flag held high, then keep it high
        cyc(1, 0, 0, 1);
        cyc(1, 0, 0, 1);
        chk("rst_pending", 32'(pending_count), 0);
        chk("rst_valid",   32'(event_valid),   0);
        chk("rst_overflow",32'(overflow),      0);
        chk("rst_armed",   32'(armed),         0);
        repeat_cyc(20, 1, 0);
        chk("high_after_rst_armed",   32'(armed),         0);
        chk("high_after_rst_pending", 32'(pending_count), 0);

        // two lows arm, four highs fire
        cyc(0, 0, 0, 0);
        chk("one_low_not_armed", 32'(armed), 0);
        cyc(0, 0, 0, 0);
        chk("two_lows_armed", 32'(armed), 1);
        repeat_cyc(3, 1, 0);
        chk("three_highs_no_event", 32'(pending_count), 0);
        cyc(1, 0, 0, 0);
        chk("first_event_pending", 32'(pending_count), 1);
        chk("first_event_valid",   32'(event_valid),   1);
        chk("after_fire_armed",    32'(armed),         0);
        repeat_cyc(MIN_LOW, 0, 0);

        // glitch filtering: 3 high, 1 low, 3 high -> nothing
        repeat_cyc(3, 1, 0);
        cyc(0, 0, 0, 0);
        repeat_cyc(3, 1, 0);
        cyc(0, 0, 0, 0);
        chk("glitch_no_event", 32'(pending_count), 1);
        // long high -> exactly one event
        repeat_cyc(9, 1, 0);
        chk("long_high_one_event", 32'(pending_count), 2);
        repeat_cyc(MIN_LOW, 0, 0);

        // drain, then queue three and drain one per edge
        repeat_cyc(3, 0, 1);
        chk("drain_empty", 32'(pending_count), 0);
        for (int i = 0; i < 3; i++) qual_event(0, 0);
        chk("queue_three", 32'(pending_count), 3);
        cyc(0, 1, 0, 0);
        chk("drain_2", 32'(pending_count), 2);
        cyc(0, 1, 0, 0);
        chk("drain_1", 32'(pending_count), 1);
        cyc(0, 1, 0, 0);
        chk("drain_0", 32'(pending_count), 0);
        chk("drain_valid_low", 32'(event_valid), 0);
        cyc(0, 1, 0, 0);
        chk("no_underflow", 32'(pending_count), 0);

        // simultaneous fire and accept
        qual_event(0, 0);
        qual_event(0, 0);
        qual_event(1, 0);
        chk("fire_accept_at_2", 32'(pending_count), 2);
        for (int i = 0; i < 13; i++) qual_event(0, 0);
        chk("fill_to_15", 32'(pending_count), 15);
        qual_event(1, 0);
        chk("fire_accept_at_15",     32'(pending_count), 15);
        chk("fire_accept_no_ovf",    32'(overflow),      0);

        // saturation and overflow clear precedence
        qual_event(0, 0);
        chk("sat_pending",  32'(pending_count), 15);
        chk("sat_overflow", 32'(overflow),      1);
        cyc(0, 0, 1, 0);
        chk("clear_overflow", 32'(overflow), 0);
        qual_event(0, 1);
        chk("set_beats_clear", 32'(overflow), 1);

        // reset mid-stream
        repeat_cyc(10, 0, 1);
        chk("drain_to_5", 32'(pending_count), 5);
        repeat_cyc(2, 1, 0);
        cyc(1, 0, 0, 1);
        chk("midrst_pending",  32'(pending_count), 0);
        chk("midrst_valid",    32'(event_valid),   0);
        chk("midrst_overflow", 32'(overflow),      0);
        chk("midrst_armed",    32'(armed),         0);
        repeat_cyc(MIN_HIGH + 2, 1, 0);
        chk("post_rst_high_ignored", 32'(pending_count), 0);
        repeat_cyc(MIN_LOW, 0, 0);
        chk("post_rst_rearmed", 32'(armed), 1);
        repeat_cyc(MIN_HIGH, 1, 0);
        chk("post_rst_event", 32'(pending_count), 1);
        repeat_cyc(3, 0, 0);

        chk("scoreboard_empty", 32'(exp_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
